req_grant_latency_monitor: RTL and testbench

- Synthesizable, multi-channel request/grant latency checker.
- Sits beside an arbiter, in the RTL or bound into the bench.
- Measures each request-to-grant latency per channel and classifies it as pass, early, timeout or spurious.
- Keeps sticky error flags and saturating totals; replaces the per-cycle concurrent assertion on a single request/grant pair.

---
 rtl/lat_mon_pkg.sv | 17 +
 rtl/req_grant_latency_monitor_if.sv | 30 +++
 rtl/lat_chan_tracker.sv | 92 +++++++++
 rtl/req_grant_latency_monitor.sv | 76 +++++++
 tb/tb_req_grant_latency_monitor.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lat_mon_pkg.sv
// Shared types and the saturating-add helper for the request/grant latency monitor.
package lat_mon_pkg;

  typedef enum logic {IDLE, WAIT} lat_state_t;

  typedef enum logic [1:0] {RES_PASS, RES_EARLY, RES_TIMEOUT, RES_SPUR} lat_result_t;

  // Width-agnostic so monitors with any CNT_W share one helper; max_val is 2^CNT_W-1.
  function automatic logic [31:0] sat_add(input logic [31:0] value,
                                          input logic [31:0] count,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, value} + {1'b0, count};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/req_grant_latency_monitor_if.sv
// Request/grant/status bundle; master drives request/grant/clr_status, slave is the monitor.
interface req_grant_latency_monitor_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]       request;
  logic [N_CH-1:0]       grant;
  logic                  clr_status;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       pass_pulse;
  logic [N_CH-1:0]       early_err;
  logic [N_CH-1:0]       timeout_err;
  logic [N_CH-1:0]       spurious_err;
  logic [N_CH-1:0]       err_sticky;
  logic [N_CH*CNT_W-1:0] last_lat;
  logic [CNT_W-1:0]      pass_cnt;
  logic [CNT_W-1:0]      fail_cnt;

  modport master (
    output request, grant, clr_status,
    input  busy, pass_pulse, early_err, timeout_err, spurious_err,
           err_sticky, last_lat, pass_cnt, fail_cnt
  );

  modport slave (
    input  request, grant, clr_status,
    output busy, pass_pulse, early_err, timeout_err, spurious_err,
           err_sticky, last_lat, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/lat_chan_tracker.sv
// One channel's IDLE/WAIT tracker: ages an open request and classifies its grant.
// Result pulses are registered (one cycle after the deciding edge); purely observational.
module lat_chan_tracker
  import lat_mon_pkg::*;
#(
  parameter int MIN_LAT = 2,
  parameter int MAX_LAT = 5,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             request_i,
  input  logic             grant_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             early_o,
  output logic             timeout_o,
  output logic             spurious_o,
  output logic [CNT_W-1:0] last_lat_o
);

  lat_state_t       state_q, state_d;
  logic [CNT_W-1:0] age_q, age_d;
  logic [CNT_W-1:0] last_lat_q, last_lat_d;
  logic             pass_q, early_q, timeout_q, spur_q;
  logic             res_vld;
  lat_result_t      res;

  always_comb begin
    state_d    = state_q;
    age_d      = age_q;
    last_lat_d = last_lat_q;
    res_vld    = 1'b0;
    res        = RES_PASS;
    case (state_q)
      IDLE: begin
        // A grant on the opening edge is still spurious; the request opens regardless.
        if (grant_i) begin
          res_vld = 1'b1;
          res     = RES_SPUR;
        end
        if (request_i) begin
          state_d = WAIT;
          age_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (grant_i) begin
          res_vld    = 1'b1;
          res        = (age_q < CNT_W'(MIN_LAT)) ? RES_EARLY : RES_PASS;
          last_lat_d = age_q;
          state_d    = IDLE;
        end else if (age_q == CNT_W'(MAX_LAT)) begin
          res_vld = 1'b1;
          res     = RES_TIMEOUT;
          state_d = IDLE;
        end else begin
          age_d = age_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      age_q      <= '0;
      last_lat_q <= '0;
      pass_q     <= 1'b0;
      early_q    <= 1'b0;
      timeout_q  <= 1'b0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      age_q      <= age_d;
      last_lat_q <= last_lat_d;
      pass_q     <= res_vld && (res == RES_PASS);
      early_q    <= res_vld && (res == RES_EARLY);
      timeout_q  <= res_vld && (res == RES_TIMEOUT);
      spur_q     <= res_vld && (res == RES_SPUR);
    end
  end

  assign busy_o     = (state_q == WAIT);
  assign pass_o     = pass_q;
  assign early_o    = early_q;
  assign timeout_o  = timeout_q;
  assign spurious_o = spur_q;
  assign last_lat_o = last_lat_q;

endmodule

// File: rtl/req_grant_latency_monitor.sv
// Multi-channel request/grant latency monitor with sticky error flags and saturating totals.
// Pulses one cycle after the deciding edge, totals one cycle later; never stalls the arbiter.
module req_grant_latency_monitor
  import lat_mon_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int MIN_LAT = 2,
  parameter int MAX_LAT = 5,
  parameter int CNT_W   = 8
) (
  input logic                     clk,
  input logic                     rst,
  req_grant_latency_monitor_if.slave mon
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [N_CH-1:0]  pass_vec, early_vec, timeout_vec, spur_vec, err_vec;
  logic [N_CH-1:0]  sticky_q, sticky_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    lat_chan_tracker #(
      .MIN_LAT (MIN_LAT),
      .MAX_LAT (MAX_LAT),
      .CNT_W   (CNT_W)
    ) u_trk (
      .clk        (clk),
      .rst        (rst),
      .request_i  (mon.request[i]),
      .grant_i    (mon.grant[i]),
      .busy_o     (mon.busy[i]),
      .pass_o     (pass_vec[i]),
      .early_o    (early_vec[i]),
      .timeout_o  (timeout_vec[i]),
      .spurious_o (spur_vec[i]),
      .last_lat_o (mon.last_lat[i*CNT_W +: CNT_W])
    );
  end

  assign err_vec = early_vec | timeout_vec | spur_vec;

  // clr_status takes priority over anything counted or flagged in the same cycle.
  always_comb begin
    sticky_d   = sticky_q | err_vec;
    pass_cnt_d = CNT_W'(sat_add(32'(pass_cnt_q), 32'($countones(pass_vec)), CNT_MAX));
    fail_cnt_d = CNT_W'(sat_add(32'(fail_cnt_q), 32'($countones(err_vec)), CNT_MAX));
    if (mon.clr_status) begin
      sticky_d   = '0;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      sticky_q   <= sticky_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign mon.pass_pulse   = pass_vec;
  assign mon.early_err    = early_vec;
  assign mon.timeout_err  = timeout_vec;
  assign mon.spurious_err = spur_vec;
  assign mon.err_sticky   = sticky_q;
  assign mon.pass_cnt     = pass_cnt_q;
  assign mon.fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_req_grant_latency_monitor.sv
// Scoreboard bench: directed stimulus queues expected pulse sets; a negedge monitor checks them.
module tb_req_grant_latency_monitor;

  typedef struct packed {
    logic [3:0] pass;
    logic [3:0] early;
    logic [3:0] tmo;
    logic [3:0] spur;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  ev_t  exp_q[$];
  int   ep = 0;
  int   ef = 0;

  always #5 clk = ~clk;

  req_grant_latency_monitor_if #(.N_CH(4), .CNT_W(8)) ifc ();
  req_grant_latency_monitor_if #(.N_CH(4), .CNT_W(4)) if1 ();

  req_grant_latency_monitor #(.N_CH(4), .MIN_LAT(2), .MAX_LAT(5), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .mon (ifc)
  );

  req_grant_latency_monitor #(.N_CH(4), .MIN_LAT(2), .MAX_LAT(5), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .mon (if1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lat(input int ch);
    return ifc.last_lat[ch*8 +: 8];
  endfunction

  function automatic ev_t ev(input logic [3:0] p, input logic [3:0] e,
                             input logic [3:0] t, input logic [3:0] s);
    ev_t r;
    r.pass = p; r.early = e; r.tmo = t; r.spur = s;
    return r;
  endfunction

  // Opens a transaction at t0, grants (or not) at edge t0+k, then drops request.
  task automatic txn(input logic [3:0] mask, input int k, input bit do_grant);
    ifc.request = mask;
    tick();
    chk("busy_open", 64'(ifc.busy & mask), 64'(mask));
    repeat (k - 1) tick();
    if (do_grant) ifc.grant = mask;
    tick();
    ifc.grant   = '0;
    ifc.request = '0;
  endtask

  initial begin : monitor
    ev_t act, e;
    forever begin
      @(negedge clk);
      act = ev(ifc.pass_pulse, ifc.early_err, ifc.timeout_err, ifc.spurious_err);
      if (act != '0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got %0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          chk("pulse", 64'(act), 64'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded bound", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    ifc.request = '0; ifc.grant = '0; ifc.clr_status = 1'b0;
    if1.request = '0; if1.grant = '0; if1.clr_status = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy", 64'(ifc.busy), 0);
    chk("rst_pass_cnt", 64'(ifc.pass_cnt), 0);
    chk("rst_fail_cnt", 64'(ifc.fail_cnt), 0);
    chk("rst_sticky", 64'(ifc.err_sticky), 0);
    chk("rst_last_lat", 64'(ifc.last_lat), 0);

    // Minimum legal latency.
    exp_q.push_back(ev(4'h1, 0, 0, 0)); ep += 1;
    txn(4'h1, 2, 1'b1);
    tick();
    chk("lat0_min", 64'(lat(0)), 2);
    chk("pass_cnt_a", 64'(ifc.pass_cnt), 64'(ep));
    chk("fail_cnt_a", 64'(ifc.fail_cnt), 64'(ef));

    // Maximum legal latency.
    exp_q.push_back(ev(4'h1, 0, 0, 0)); ep += 1;
    txn(4'h1, 5, 1'b1);
    tick();
    chk("lat0_max", 64'(lat(0)), 5);
    chk("pass_cnt_b", 64'(ifc.pass_cnt), 64'(ep));

    // Timeout leaves last_lat alone.
    exp_q.push_back(ev(0, 0, 4'h1, 0)); ef += 1;
    txn(4'h1, 5, 1'b0);
    tick();
    chk("lat0_after_tmo", 64'(lat(0)), 5);
    chk("sticky_tmo", 64'(ifc.err_sticky), 64'h1);
    chk("fail_cnt_tmo", 64'(ifc.fail_cnt), 64'(ef));

    // Early grant at t0+1.
    exp_q.push_back(ev(0, 4'h2, 0, 0)); ef += 1;
    txn(4'h2, 1, 1'b1);
    tick();
    chk("lat1_early", 64'(lat(1)), 1);
    chk("fail_cnt_early", 64'(ifc.fail_cnt), 64'(ef));

    // Spurious grant while idle does not open a transaction.
    exp_q.push_back(ev(0, 0, 0, 4'h2)); ef += 1;
    ifc.grant = 4'h2;
    tick();
    ifc.grant = '0;
    chk("busy_spur", 64'(ifc.busy), 0);
    tick();
    chk("fail_cnt_spur", 64'(ifc.fail_cnt), 64'(ef));

    // All channels at t0+3, request held: back-to-back reopen, then pass at t0'+2.
    exp_q.push_back(ev(4'hF, 0, 0, 0));
    exp_q.push_back(ev(4'hF, 0, 0, 0)); ep += 8;
    ifc.request = 4'hF;
    tick();
    chk("busy_all", 64'(ifc.busy), 64'hF);
    tick(); tick();
    ifc.grant = 4'hF;
    tick();
    ifc.grant = '0;
    chk("busy_closed", 64'(ifc.busy), 0);
    tick();
    chk("busy_reopen", 64'(ifc.busy), 64'hF);
    tick();
    ifc.grant = 4'hF;
    tick();
    ifc.grant = '0; ifc.request = '0;
    tick();
    chk("pass_cnt_all", 64'(ifc.pass_cnt), 64'(ep));
    chk("lat2_b2b", 64'(lat(2)), 2);

    // Grant on the opening edge: spurious, yet the transaction opens and passes.
    exp_q.push_back(ev(0, 0, 0, 4'h8)); ef += 1;
    exp_q.push_back(ev(4'h8, 0, 0, 0)); ep += 1;
    ifc.request = 4'h8; ifc.grant = 4'h8;
    tick();
    ifc.grant = '0;
    chk("busy_t0_spur", 64'(ifc.busy), 64'h8);
    tick();
    ifc.grant = 4'h8;
    tick();
    ifc.grant = '0; ifc.request = '0;
    tick();
    chk("pass_cnt_t0", 64'(ifc.pass_cnt), 64'(ep));
    chk("fail_cnt_t0", 64'(ifc.fail_cnt), 64'(ef));
    chk("sticky_all", 64'(ifc.err_sticky), 64'hB);

    // clr_status in the same cycle as a pass pulse.
    exp_q.push_back(ev(4'h1, 0, 0, 0));
    txn(4'h1, 2, 1'b1);
    ifc.clr_status = 1'b1;
    tick();
    ifc.clr_status = 1'b0;
    ep = 0; ef = 0;
    chk("clr_pass_cnt", 64'(ifc.pass_cnt), 0);
    chk("clr_fail_cnt", 64'(ifc.fail_cnt), 0);
    chk("clr_sticky", 64'(ifc.err_sticky), 0);
    chk("clr_keeps_lat", 64'(lat(0)), 2);

    // Saturation on the 4-bit instance: 20 passes stop at 15.
    for (int it = 0; it < 5; it++) begin
      if1.request = 4'hF;
      tick(); tick();
      if1.grant = 4'hF;
      tick();
      if1.grant = '0; if1.request = '0;
      tick();
      if (it == 2) chk("sat_mid", 64'(if1.pass_cnt), 12);
    end
    chk("sat_pass_cnt", 64'(if1.pass_cnt), 15);
    chk("sat_fail_cnt", 64'(if1.fail_cnt), 0);
    if1.request = 4'h1;
    tick(); tick();
    if1.grant = 4'h1;
    tick();
    if1.grant = '0; if1.request = '0;
    if1.clr_status = 1'b1;
    tick();
    if1.clr_status = 1'b0;
    chk("sat_clr", 64'(if1.pass_cnt), 0);
    tick();
    chk("sat_clr_hold", 64'(if1.pass_cnt), 0);

    // Counters live again, then reset mid-transaction on ch2.
    exp_q.push_back(ev(4'h1, 0, 0, 0)); ep += 1;
    txn(4'h1, 3, 1'b1);
    tick();
    chk("pass_cnt_pre_rst", 64'(ifc.pass_cnt), 64'(ep));
    ifc.request = 4'h4;
    tick();
    chk("busy_ch2", 64'(ifc.busy), 64'h4);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ifc.request = '0;
    chk("rst_mid_busy", 64'(ifc.busy), 0);
    chk("rst_mid_pass_cnt", 64'(ifc.pass_cnt), 0);
    chk("rst_mid_fail_cnt", 64'(ifc.fail_cnt), 0);
    chk("rst_mid_last_lat", 64'(ifc.last_lat), 0);
    repeat (3) tick();
    chk("rst_mid_sticky", 64'(ifc.err_sticky), 0);

    tick();
    chk("pending_exp", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
